hs32_opfetch: RTL and testbench

HS32_OPFETCH -- requirements
Module: hs32_opfetch

---
 rtl/hs32_opfetch.sv | 79 +++++++
 tb/tb_hs32_opfetch.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/hs32_opfetch.sv
// hs32_opfetch: operand fetch stage with forwarding, hazard stall, shifter and opcode decode
module hs32_opfetch #(
  parameter int WIDTH = 32,
  parameter int NFWD  = 2,
  parameter int SHW   = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4:0]            in_opc,
  input  logic [3:0]            in_rd,
  input  logic [3:0]            in_rm,
  input  logic [WIDTH-1:0]      in_d2,
  input  logic [SHW-1:0]        in_shl,
  input  logic [SHW-1:0]        in_shr,
  input  logic                  in_maskl,
  input  logic                  in_maskr,
  input  logic                  in_sext,
  output logic [3:0]            rp_addr_o,
  input  logic [WIDTH-1:0]      rp_data_i,
  input  logic [NFWD-1:0]       fwd_valid_i,
  input  logic [NFWD-1:0]       fwd_busy_i,
  input  logic [4*NFWD-1:0]     fwd_rd_i,
  input  logic [WIDTH*NFWD-1:0] fwd_data_i,
  input  logic                  flush_i,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_d1,
  output logic [WIDTH-1:0]      out_d2,
  output logic [3:0]            out_rd,
  output logic [5:0]            out_ctl,
  output logic [15:0]           stall_cnt_o
);
  logic hazard, accept, alu, sub, cen, neg;
  logic [1:0] opr;
  logic [WIDTH-1:0] d1, d2;
  logic signed [WIDTH:0] ext, sra;
  assign rp_addr_o = in_rm;
  // scan from the oldest source down so the youngest match wins
  always_comb begin
    hazard = 1'b0;
    d1 = rp_data_i;
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (fwd_busy_i[i] && fwd_rd_i[4*i +: 4] == in_rm) hazard = 1'b1;
      if (fwd_valid_i[i] && fwd_rd_i[4*i +: 4] == in_rm) d1 = fwd_data_i[WIDTH*i +: WIDTH];
    end
    hazard = hazard & in_valid;
  end
  assign in_ready = ~rst & (~out_valid | out_ready) & ~hazard;
  assign accept = in_valid & in_ready;
  assign ext = {in_sext & in_d2[WIDTH-1], in_d2};
  assign sra = ext >>> in_shr;
  assign d2 = (in_maskr ? sra[WIDTH-1:0] : '0) | (in_maskl ? in_d2 << in_shl : '0);
  assign alu = in_opc[4];
  assign sub = alu & ~in_opc[2] & in_opc[1];
  assign cen = alu & ~in_opc[2] & in_opc[0];
  assign neg = sub | (alu & in_opc[2:0] == 3'b101);
  assign opr = ~alu ? 2'd0 : ~in_opc[2] ? 2'd0 : ~in_opc[1] ? 2'd1 : in_opc[0] ? 2'd3 : 2'd2;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_d1 <= '0;
      out_d2 <= '0;
      out_rd <= '0;
      out_ctl <= '0;
      stall_cnt_o <= '0;
    end else begin
      out_valid <= ~flush_i & (accept | (out_valid & ~out_ready));
      if (accept) begin
        out_d1 <= in_opc[4:2] == 3'b000 ? '0 : d1;
        out_d2 <= d2;
        out_rd <= in_rd;
        out_ctl <= {in_opc[4], opr, cen, sub, neg};
      end
      if (hazard && stall_cnt_o != 16'hFFFF) stall_cnt_o <= stall_cnt_o + 16'd1;
    end
  end
endmodule

// File: tb/tb_hs32_opfetch.sv
// tb_hs32_opfetch: directed steps with a scoreboard of expected output packets
module tb_hs32_opfetch;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready;
  logic [4:0] opc = 0;
  logic [3:0] rd = 0, rm = 0, rp_addr;
  logic [31:0] d2in = 0, rp_data;
  logic [4:0] shl = 0, shr = 0;
  logic maskl = 0, maskr = 0, sext = 0;
  logic [1:0] fwd_valid = 0, fwd_busy = 0;
  logic [7:0] fwd_rd = 0;
  logic [63:0] fwd_data = 0;
  logic flush = 0, out_valid, out_ready = 1;
  logic [31:0] out_d1, out_d2;
  logic [3:0] out_rd;
  logic [5:0] out_ctl;
  logic [15:0] stall_cnt;
  logic [31:0] regs [16];
  logic [73:0] sb [$];
  int tests = 0, fails = 0;

  assign rp_data = regs[rp_addr];

  hs32_opfetch dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_opc(opc),
    .in_rd(rd), .in_rm(rm), .in_d2(d2in), .in_shl(shl), .in_shr(shr),
    .in_maskl(maskl), .in_maskr(maskr), .in_sext(sext), .rp_addr_o(rp_addr),
    .rp_data_i(rp_data), .fwd_valid_i(fwd_valid), .fwd_busy_i(fwd_busy),
    .fwd_rd_i(fwd_rd), .fwd_data_i(fwd_data), .flush_i(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_d1(out_d1), .out_d2(out_d2), .out_rd(out_rd),
    .out_ctl(out_ctl), .stall_cnt_o(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // reference packet {d1, d2, rd, ctl} from the currently driven inputs
  function automatic logic [73:0] model();
    logic [31:0] d1, sr, sl;
    logic [63:0] ext;
    logic [5:0] ctl;
    d1 = regs[rm];
    if (fwd_valid[1] && fwd_rd[7:4] == rm) d1 = fwd_data[63:32];
    if (fwd_valid[0] && fwd_rd[3:0] == rm) d1 = fwd_data[31:0];
    if (opc[4:2] == 3'b000) d1 = 0;
    ext = {{32{sext & d2in[31]}}, d2in} >> shr;
    sr = maskr ? ext[31:0] : 32'h0;
    sl = maskl ? d2in << shl : 32'h0;
    case ({opc[4], opc[2:0]})
      4'b1000: ctl = 6'b100000;
      4'b1001: ctl = 6'b100100;
      4'b1010: ctl = 6'b100011;
      4'b1011: ctl = 6'b100111;
      4'b1100: ctl = 6'b101000;
      4'b1101: ctl = 6'b101001;
      4'b1110: ctl = 6'b110000;
      4'b1111: ctl = 6'b111000;
      default: ctl = 6'b000000;
    endcase
    return {d1, sr | sl, rd, ctl};
  endfunction

  always @(negedge clk) begin
    logic [73:0] e;
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $error("FAIL sb_underflow: observed unexpected packet d1=%h expected none", out_d1);
        end else begin
          e = sb.pop_front();
          chk("sb_d1", out_d1, e[73:42]);
          chk("sb_d2", out_d2, e[41:10]);
          chk("sb_rd", out_rd, e[9:6]);
          chk("sb_ctl", out_ctl, e[5:0]);
        end
      end else if (out_valid && flush && sb.size() != 0) begin
        e = sb.pop_front();
      end
      if (in_valid && in_ready && !flush) sb.push_back(model());
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = $urandom;
    regs[3] = 32'h11;
    regs[4] = 32'h4444;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    cyc();
    cyc();
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_d1", out_d1, 0);
    chk("rst_ctl", out_ctl, 0);
    rst = 0;
    cyc();
    // mov: d1 forced to zero
    opc = 5'b00011; rd = 1; rm = 2; d2in = 32'h1234; maskr = 1; in_valid = 1;
    cyc();
    // forwarding priority: youngest source wins
    opc = 5'b10010; rd = 2; rm = 3; maskr = 0; maskl = 1; shl = 4;
    fwd_valid = 2'b11; fwd_rd = 8'h33; fwd_data = 64'hBB_0000_00AA;
    cyc();
    in_valid = 0;
    @(negedge clk);
    chk("fwd_prio_d1", out_d1, 32'hAA);
    chk("fwd_prio_ctl", out_ctl, 6'b100011);
    for (int i = 0; i < 16; i++) begin
      opc = 5'($urandom); rd = 4'($urandom); rm = 4'($urandom); d2in = $urandom;
      shl = 5'($urandom); shr = 5'($urandom);
      {maskl, maskr, sext} = 3'($urandom);
      fwd_valid = 2'($urandom); fwd_rd = 8'($urandom); fwd_data = {$urandom, $urandom};
      in_valid = 1;
      cyc();
    end
    // arithmetic vs logical right shift
    fwd_valid = 0; opc = 5'b10100; rd = 9; d2in = 32'h8000_0000; shr = 4; sext = 1;
    maskr = 1; maskl = 0;
    cyc();
    sext = 0;
    @(negedge clk);
    chk("shift_sext", out_d2, 32'hF800_0000);
    cyc();
    in_valid = 0;
    @(negedge clk);
    chk("shift_logic", out_d2, 32'h0800_0000);
    cyc();
    // busy source 1 on r5 stalls; a valid match on r5 does not override it
    chk("stall_pre", stall_cnt, 0);
    opc = 5'b10001; rd = 6; rm = 5; d2in = 32'h99; shr = 0; in_valid = 1;
    fwd_busy = 2'b10; fwd_rd = 8'h55; fwd_valid = 2'b01; fwd_data = 64'h5555;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      cyc();
    end
    fwd_busy = 0;
    @(negedge clk);
    chk("stall_cnt3", stall_cnt, 3);
    chk("stall_release", in_ready, 1);
    cyc();
    in_valid = 0; fwd_valid = 0;
    cyc();
    // backpressure holds the output and blocks input
    out_ready = 0;
    opc = 5'b10000; rd = 7; rm = 4; d2in = 32'h55; in_valid = 1;
    cyc();
    d2in = 32'h66; rd = 8;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_d2", out_d2, 32'h55);
      chk("bp_rd", out_rd, 7);
      cyc();
    end
    out_ready = 1;
    @(negedge clk);
    chk("bp_release", in_ready, 1);
    cyc();
    // flush beats a simultaneous accept
    d2in = 32'h77; rd = 10; flush = 1;
    @(negedge clk);
    chk("flush_in_ready", in_ready, 1);
    cyc();
    flush = 0; in_valid = 0;
    @(negedge clk);
    chk("flush_valid", out_valid, 0);
    cyc();
    // reset in the middle of a stall with a held packet
    out_ready = 0; rm = 2; in_valid = 1;
    cyc();
    rm = 5; fwd_busy = 2'b10; fwd_rd = 8'h50;
    cyc();
    cyc();
    @(negedge clk);
    chk("stall_cnt5", stall_cnt, 5);
    chk("held_valid", out_valid, 1);
    rst = 1;
    #1;
    chk("rst_blocks_ready", in_ready, 0);
    cyc();
    rst = 0; fwd_busy = 0; in_valid = 0; out_ready = 1;
    sb.delete();
    @(negedge clk);
    chk("midrst_stall", stall_cnt, 0);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_d2", out_d2, 0);
    cyc();
    opc = 5'b11111; rd = 11; rm = 4; d2in = 32'h1; maskl = 1; shl = 31; maskr = 0; in_valid = 1;
    cyc();
    in_valid = 0;
    @(negedge clk);
    chk("last_d2", out_d2, 32'h8000_0000);
    chk("last_ctl", out_ctl, 6'b111000);
    cyc();
    cyc();
    @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
